// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions used by the memory-stage load/store unit.
// Access sizes, funct3 encodings, FSM states and the captured request record.
package riscv_pkg;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD
    } mem_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    typedef struct packed {
        logic        we;
        logic        is_load;
        mem_size_t   size;
        logic        is_unsigned;
        logic [1:0]  offset;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } lsu_req_t;

    // Reserved encodings fall through to a word access.
    function automatic mem_size_t decode_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: decode_size = BYTE;
            F3_H, F3_HU: decode_size = HALF;
            default:     decode_size = WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/grant/response bus between the load/store unit and data memory.
interface load_store_unit_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables/replication and load lane select/extension.
module lsu_align
    import riscv_pkg::*;
(
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] load_value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (size)
            BYTE: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            HALF: begin
                be    = offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Half accesses ignore offset[0], so the upper half is chosen by offset[1] alone.
    always_comb begin
        byte_lane  = rdata[{offset, 3'b000} +: 8];
        half_lane  = offset[1] ? rdata[31:16] : rdata[15:0];
        load_value = rdata;
        case (size)
            BYTE:    load_value = is_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            HALF:    load_value = is_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_value = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: FSM driving the data-memory handshake, request capture and load result.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of aligning them.
module load_store_unit
    import riscv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic               load_en,
    input  logic               store_en,
    input  logic [2:0]         funct3,
    input  logic [31:0]        addr,
    input  logic [31:0]        store_data,
    input  logic [4:0]         rd_addr_in,
    input  logic [31:0]        rd_in,
    input  logic               writeback_en_in,
    output logic               valid_out,
    output logic [4:0]         rd_addr_out,
    output logic [31:0]        rd_out,
    output logic               writeback_en_out,
    output logic               stall,
    output logic               misalign_exc,
    load_store_unit_if.master  dmem
);

    lsu_state_t  state, state_next;
    lsu_req_t    req_q, req_live;
    logic [31:0] load_data_q;
    logic        is_mem;
    logic        misaligned;
    logic        rd_write_ok;
    mem_size_t   size_live;

    mem_size_t   align_size;
    logic        align_unsigned;
    logic [1:0]  align_offset;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_load;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;

    assign is_mem      = valid_in && (load_en || store_en);
    assign size_live   = decode_size(funct3);
    assign rd_write_ok = writeback_en_in && (rd_addr_in != 5'd0);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = is_mem &&
                        (((size_live == HALF) && addr[0]) ||
                         ((size_live == WORD) && (addr[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    // In IDLE the aligner shapes the live store; afterwards it extends the registered load lane.
    assign align_size     = (state == IDLE) ? size_live : req_q.size;
    assign align_unsigned = (state == IDLE) ? (funct3[2] && (size_live != WORD)) : req_q.is_unsigned;
    assign align_offset   = (state == IDLE) ? addr[1:0] : req_q.offset;

    lsu_align u_align (
        .size        (align_size),
        .is_unsigned (align_unsigned),
        .offset      (align_offset),
        .store_data  (store_data),
        .be          (align_be),
        .wdata       (align_wdata),
        .rdata       (dmem.rdata),
        .load_value  (align_load)
    );

    always_comb begin
        req_live.we          = !load_en;
        req_live.is_load     = load_en;
        req_live.size        = size_live;
        req_live.is_unsigned = funct3[2] && (size_live != WORD);
        req_live.offset      = addr[1:0];
        req_live.addr        = {addr[31:2], 2'b00};
        req_live.be          = align_be;
        req_live.wdata       = align_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_q       <= '0;
            load_data_q <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && is_mem && !misaligned) begin
                req_q <= req_live;
            end
            if ((state == WAIT) && dmem.rvalid) begin
                load_data_q <= align_load;
            end
        end
    end

    always_comb begin
        state_next       = state;
        stall            = 1'b0;
        valid_out        = 1'b0;
        rd_addr_out      = '0;
        rd_out           = '0;
        writeback_en_out = 1'b0;
        misalign_exc     = 1'b0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_be           = '0;
        mem_wdata        = '0;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    misalign_exc = 1'b1;
                    valid_out    = 1'b1;
                    rd_addr_out  = rd_addr_in;
                    rd_out       = rd_in;
                end else if (is_mem) begin
                    stall     = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = req_live.we;
                    mem_addr  = req_live.addr;
                    mem_be    = req_live.be;
                    mem_wdata = req_live.wdata;
                    if (dmem.gnt) begin
                        state_next = req_live.is_load ? WAIT : DONE;
                    end else begin
                        state_next = REQ;
                    end
                end else begin
                    valid_out        = valid_in;
                    rd_addr_out      = rd_addr_in;
                    rd_out           = rd_in;
                    writeback_en_out = valid_in && rd_write_ok;
                end
            end
            REQ: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = req_q.we;
                mem_addr  = req_q.addr;
                mem_be    = req_q.be;
                mem_wdata = req_q.wdata;
                if (dmem.gnt) begin
                    state_next = req_q.is_load ? WAIT : DONE;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem.rvalid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid_out        = 1'b1;
                rd_addr_out      = rd_addr_in;
                rd_out           = req_q.is_load ? load_data_q : rd_in;
                writeback_en_out = req_q.is_load && rd_write_ok;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dmem.req   = mem_req;
    assign dmem.we    = mem_we;
    assign dmem.addr  = mem_addr;
    assign dmem.be    = mem_be;
    assign dmem.wdata = mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed vectors queue expected results, a monitor checks them.
module tb_load_store_unit;
    import riscv_pkg::*;

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic [31:0] rin;
        logic        wb;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] rdata;
        logic        spur;
        logic [31:0] exp_rd_out;
        logic        exp_wb;
        logic        exp_exc;
        int          exp_stall;
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_daddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [4:0]  rd_addr;
        logic [31:0] rd_out;
        logic        wb;
        logic        exc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, load_en, store_en;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, rd_in;
    logic [4:0]  rd_addr_in;
    logic        writeback_en_in;
    logic        valid_out, writeback_en_out, stall, misalign_exc;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_out;

    int   test_count = 0;
    int   fail_count = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    load_store_unit_if dmem();

    load_store_unit dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .load_en          (load_en),
        .store_en         (store_en),
        .funct3           (funct3),
        .addr             (addr),
        .store_data       (store_data),
        .rd_addr_in       (rd_addr_in),
        .rd_in            (rd_in),
        .writeback_en_in  (writeback_en_in),
        .valid_out        (valid_out),
        .rd_addr_out      (rd_addr_out),
        .rd_out           (rd_out),
        .writeback_en_out (writeback_en_out),
        .stall            (stall),
        .misalign_exc     (misalign_exc),
        .dmem             (dmem)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input string name, input logic ld, st, input logic [2:0] f3,
                                input logic [31:0] a, sd, input logic [4:0] rd, input logic [31:0] rin,
                                input logic wb, input int gd, rv, input logic [31:0] rdata, input logic spur,
                                input logic [31:0] e_rd, input logic e_wb, e_exc, input int e_stall,
                                input logic e_req, e_we, input logic [31:0] e_daddr,
                                input logic [3:0] e_be, input logic [31:0] e_wdata);
        vec_t v;
        v.name = name; v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.sdata = sd;
        v.rd = rd; v.rin = rin; v.wb = wb; v.gnt_dly = gd; v.rv_dly = rv; v.rdata = rdata;
        v.spur = spur; v.exp_rd_out = e_rd; v.exp_wb = e_wb; v.exp_exc = e_exc;
        v.exp_stall = e_stall; v.exp_req = e_req; v.exp_we = e_we; v.exp_daddr = e_daddr;
        v.exp_be = e_be; v.exp_wdata = e_wdata;
        return v;
    endfunction

    // Monitor: every presented result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && valid_out) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_valid_out", {27'b0, rd_addr_out}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("mon_rd_addr", {27'b0, rd_addr_out}, {27'b0, e.rd_addr});
                checkOutput("mon_wb", {31'b0, writeback_en_out}, {31'b0, e.wb});
                checkOutput("mon_exc", {31'b0, misalign_exc}, {31'b0, e.exc});
                if (!e.exc) checkOutput("mon_rd_out", rd_out, e.rd_out);
            end
        end
        if (!rst && misalign_exc && !valid_out) begin
            checkOutput("exc_without_valid", {31'b0, valid_out}, 32'd1);
        end
    end

    task automatic applyStimulus(input vec_t v);
        int   req_cnt, wait_cnt, stall_cnt;
        logic req_seen, finished;
        exp_t e;
        @(posedge clk); #1;
        valid_in = 1'b1; load_en = v.ld; store_en = v.st; funct3 = v.f3; addr = v.addr;
        store_data = v.sdata; rd_addr_in = v.rd; rd_in = v.rin; writeback_en_in = v.wb;
        dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
        e.rd_addr = v.rd; e.rd_out = v.exp_rd_out; e.wb = v.exp_wb; e.exc = v.exp_exc;
        sb_q.push_back(e);
        req_cnt = 0; wait_cnt = 0; stall_cnt = 0; req_seen = 1'b0; finished = 1'b0;
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            @(negedge clk);
            if (!stall) finished = 1'b1;
            else stall_cnt++;
            if (dmem.req) begin
                req_seen = 1'b1;
                checkOutput({v.name, "_daddr"}, dmem.addr, v.exp_daddr);
                checkOutput({v.name, "_be"}, {28'b0, dmem.be}, {28'b0, v.exp_be});
                checkOutput({v.name, "_we"}, {31'b0, dmem.we}, {31'b0, v.exp_we});
                if (v.exp_we) checkOutput({v.name, "_wdata"}, dmem.wdata, v.exp_wdata);
                dmem.gnt    = (req_cnt == v.gnt_dly);
                dmem.rvalid = v.spur;
                dmem.rdata  = 32'hFFFF_FFFF;
                req_cnt++;
            end else if (stall) begin
                dmem.gnt    = 1'b0;
                dmem.rvalid = (wait_cnt == v.rv_dly);
                dmem.rdata  = v.rdata;
                wait_cnt++;
            end else begin
                dmem.gnt    = 1'b0;
                dmem.rvalid = 1'b0;
            end
        end
        checkOutput({v.name, "_done"}, {31'b0, finished}, 32'd1);
        @(posedge clk); #1;
        valid_in = 1'b0; load_en = 1'b0; store_en = 1'b0;
        dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
        checkOutput({v.name, "_stall_cycles"}, stall_cnt, v.exp_stall);
        checkOutput({v.name, "_req_seen"}, {31'b0, req_seen}, {31'b0, v.exp_req});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; load_en = 1'b0; store_en = 1'b0; funct3 = '0;
        addr = '0; store_data = '0; rd_addr_in = '0; rd_in = '0; writeback_en_in = 1'b0;
        dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid_out", {31'b0, valid_out}, 32'd0);
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        checkOutput("rst_dmem_req", {31'b0, dmem.req}, 32'd0);
        checkOutput("rst_misalign", {31'b0, misalign_exc}, 32'd0);
        checkOutput("rst_load_data_q", dut.load_data_q, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        vecs.push_back(mk("add", 0, 0, 3'b000, 32'h0, 32'h0, 5'd5, 32'h10, 1, 0, 0, 32'h0, 0,
                          32'h10, 1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0));
        vecs.push_back(mk("nonmem_x0", 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h77, 1, 0, 0, 32'h0, 0,
                          32'h77, 0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0));
        vecs.push_back(mk("sb", 0, 1, F3_B, 32'h103, 32'hAB, 5'd3, 32'h103, 1, 2, 0, 32'h0, 0,
                          32'h103, 0, 0, 3, 1, 1, 32'h100, 4'b1000, 32'hABAB_ABAB));
        vecs.push_back(mk("sh", 0, 1, F3_H, 32'h102, 32'h1234_CDEF, 5'd4, 32'h102, 0, 0, 0, 32'h0, 0,
                          32'h102, 0, 0, 1, 1, 1, 32'h100, 4'b1100, 32'hCDEF_CDEF));
        vecs.push_back(mk("sw", 0, 1, F3_W, 32'h200, 32'hDEAD_BEEF, 5'd6, 32'h200, 0, 1, 0, 32'h0, 0,
                          32'h200, 0, 0, 2, 1, 1, 32'h200, 4'b1111, 32'hDEAD_BEEF));
        vecs.push_back(mk("lb", 1, 0, F3_B, 32'h101, 32'h0, 5'd7, 32'h101, 1, 0, 0, 32'h0000_8000, 0,
                          32'hFFFF_FF80, 1, 0, 2, 1, 0, 32'h100, 4'b0010, 32'h0));
        vecs.push_back(mk("lbu", 1, 0, F3_BU, 32'h101, 32'h0, 5'd7, 32'h101, 1, 0, 0, 32'h0000_8000, 0,
                          32'h0000_0080, 1, 0, 2, 1, 0, 32'h100, 4'b0010, 32'h0));
        vecs.push_back(mk("lhu", 1, 0, F3_HU, 32'h102, 32'h0, 5'd8, 32'h102, 1, 1, 1, 32'hBEEF_1234, 0,
                          32'h0000_BEEF, 1, 0, 4, 1, 0, 32'h100, 4'b1100, 32'h0));
        vecs.push_back(mk("lh_x0", 1, 0, F3_H, 32'h102, 32'h0, 5'd0, 32'h102, 1, 0, 0, 32'hBEEF_1234, 0,
                          32'hFFFF_BEEF, 0, 0, 2, 1, 0, 32'h100, 4'b1100, 32'h0));
        vecs.push_back(mk("lh_low", 1, 0, F3_H, 32'h100, 32'h0, 5'd9, 32'h100, 1, 0, 0, 32'h0000_8001, 0,
                          32'hFFFF_8001, 1, 0, 2, 1, 0, 32'h100, 4'b0011, 32'h0));
        vecs.push_back(mk("lw_spur", 1, 0, F3_W, 32'h100, 32'h0, 5'd10, 32'h100, 1, 1, 0, 32'h1234_5678, 1,
                          32'h1234_5678, 1, 0, 3, 1, 0, 32'h100, 4'b1111, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk("lw_mis", 1, 0, F3_W, 32'h102, 32'h0, 5'd11, 32'h102, 1, 0, 0, 32'hCAFE_F00D, 0,
                          32'h0, 0, 1, 0, 0, 0, 32'h0, 4'h0, 32'h0));
`else
        vecs.push_back(mk("lw_mis", 1, 0, F3_W, 32'h102, 32'h0, 5'd11, 32'h102, 1, 0, 0, 32'hCAFE_F00D, 0,
                          32'hCAFE_F00D, 1, 0, 2, 1, 0, 32'h100, 4'b1111, 32'h0));
`endif
        vecs.push_back(mk("ld_and_st", 1, 1, F3_W, 32'h104, 32'h99, 5'd12, 32'h104, 1, 0, 0, 32'hA5A5_0F0F, 0,
                          32'hA5A5_0F0F, 1, 0, 2, 1, 0, 32'h104, 4'b1111, 32'h0));
        vecs.push_back(mk("reserved_f3", 1, 0, 3'b011, 32'h108, 32'h0, 5'd13, 32'h108, 1, 0, 0, 32'h0BAD_F00D, 0,
                          32'h0BAD_F00D, 1, 0, 2, 1, 0, 32'h108, 4'b1111, 32'h0));

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset while a load waits for its data; the late response must be dropped.
        @(posedge clk); #1;
        valid_in = 1'b1; load_en = 1'b1; funct3 = F3_W; addr = 32'h300;
        rd_addr_in = 5'd14; rd_in = 32'h300; writeback_en_in = 1'b1;
        @(negedge clk);
        checkOutput("rstw_req", {31'b0, dmem.req}, 32'd1);
        dmem.gnt = 1'b1;
        @(negedge clk);
        checkOutput("rstw_in_wait_stall", {31'b0, stall}, 32'd1);
        checkOutput("rstw_in_wait_req", {31'b0, dmem.req}, 32'd0);
        dmem.gnt = 1'b0; rst = 1'b1; valid_in = 1'b0; load_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = 32'h55AA_55AA;
        @(negedge clk);
        checkOutput("rstw_valid_out", {31'b0, valid_out}, 32'd0);
        checkOutput("rstw_stall", {31'b0, stall}, 32'd0);
        checkOutput("rstw_req_after", {31'b0, dmem.req}, 32'd0);
        @(posedge clk); #1;
        dmem.rvalid = 1'b0;
        @(negedge clk);
        checkOutput("rstw_valid_out_late", {31'b0, valid_out}, 32'd0);
        checkOutput("rstw_load_data_q", dut.load_data_q, 32'd0);

        applyStimulus(mk("add_after_rst", 0, 0, 3'b000, 32'h0, 32'h0, 5'd15, 32'h1234, 1, 0, 0, 32'h0, 0,
                         32'h1234, 1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0));

        repeat (2) @(posedge clk);
        checkOutput("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
